// File: rtl/syn_md_decoder.sv
// SYN_MD receive decoder: synchronises and deglitches the pulse train, measures
// period/high width in clkin ticks and tracks lock / loss-of-sync status.
module syn_md_decoder #(
    parameter int CNT_W   = 16,
    parameter int FILT    = 3,
    parameter int TIMEOUT = 50000,
    parameter int TOL     = 4,
    parameter int LOCK_N  = 4
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             syn_md_in,
    input  logic             en,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_w,
    output logic             meas_valid,
    output logic             sync_lock,
    output logic             sync_lost
);
    typedef enum logic [1:0] {IDLE, FIRST, HIGH, LOW} state_t;

    localparam int                LCK_W   = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [LCK_W-1:0]  LOCK_V  = LCK_W'(LOCK_N);
    localparam logic [CNT_W:0]    TOL_V   = (CNT_W + 1)'(TOL);

    state_t            state, state_nxt;
    logic              s1, s2, filt, filt_d;
    logic [3:0]        filt_cnt;
    logic              rise, fall, timeout_hit, in_tol;
    logic              latch_hw, latch_meas;
    logic [CNT_W-1:0]  cnt, hw_tmp;
    logic [CNT_W:0]    diff;
    logic [LCK_W-1:0]  lock_cnt;
    logic              first_meas, meas_ok, lost_r;

    // Synchroniser and glitch filter: filt follows s2 only after FILT agreeing cycles.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            filt     <= 1'b0;
            filt_d   <= 1'b0;
            filt_cnt <= '0;
        end else begin
            s1     <= syn_md_in;
            s2     <= s1;
            filt_d <= filt;
            if (s2 != filt) begin
                if (filt_cnt == 4'(FILT - 1)) begin
                    filt     <= s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 4'd1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign rise        = filt & ~filt_d;
    assign fall        = ~filt & filt_d;
    assign timeout_hit = en && (state == HIGH || state == LOW) && (cnt == TO_VAL || cnt == CNT_MAX);
    assign diff        = (cnt >= period) ? ({1'b0, cnt} - {1'b0, period})
                                         : ({1'b0, period} - {1'b0, cnt});
    assign in_tol      = diff <= TOL_V;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        latch_hw   = 1'b0;
        latch_meas = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  state_nxt = FIRST;
                FIRST: if (rise) state_nxt = HIGH;
                HIGH: begin
                    if (timeout_hit) state_nxt = FIRST;
                    else if (rise)   state_nxt = HIGH;
                    else if (fall) begin
                        latch_hw  = 1'b1;
                        state_nxt = LOW;
                    end
                end
                LOW: begin
                    if (timeout_hit) state_nxt = FIRST;
                    else if (rise) begin
                        latch_meas = 1'b1;
                        state_nxt  = HIGH;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            hw_tmp     <= '0;
            period     <= '0;
            high_w     <= '0;
            meas_valid <= 1'b0;
            meas_ok    <= 1'b0;
            first_meas <= 1'b0;
            lock_cnt   <= '0;
            lost_r     <= 1'b0;
        end else begin
            if (state == IDLE)        cnt <= '0;
            else if (rise)            cnt <= CNT_W'(1);
            else if (cnt != CNT_MAX)  cnt <= cnt + CNT_W'(1);

            meas_valid <= latch_meas;
            if (latch_hw) hw_tmp <= cnt;
            if (state == IDLE || state == FIRST) first_meas <= 1'b1;
            // Consistency is judged against the previous period before it is overwritten.
            if (latch_meas) begin
                period     <= cnt;
                high_w     <= hw_tmp;
                meas_ok    <= !first_meas && in_tol;
                first_meas <= 1'b0;
                lost_r     <= 1'b0;
            end
            if (timeout_hit) lost_r <= 1'b1;

            if (!en || timeout_hit)  lock_cnt <= '0;
            else if (meas_valid)     lock_cnt <= !meas_ok ? LCK_W'(1)
                                               : (lock_cnt == LOCK_V) ? lock_cnt
                                               : lock_cnt + LCK_W'(1);
        end
    end

    assign sync_lock = (lock_cnt == LOCK_V) && !timeout_hit;
    assign sync_lost = lost_r || timeout_hit;
endmodule

// File: tb/tb_syn_md_decoder.sv
// Randomised scoreboard bench for syn_md_decoder: pulse trains with glitches,
// jitter, timeout, enable drop and mid-frame reset against a cycle-count model.
module tb_syn_md_decoder;
    localparam int CNT_W = 16, FILT = 3, TIMEOUT = 5000, TOL = 4, LOCK_N = 4;

    logic             clk = 1'b0, rst_n = 1'b0, syn = 1'b0, en = 1'b0;
    logic [CNT_W-1:0] period, high_w;
    logic             meas_valid, sync_lock, sync_lost;

    syn_md_decoder #(.CNT_W(CNT_W), .FILT(FILT), .TIMEOUT(TIMEOUT), .TOL(TOL), .LOCK_N(LOCK_N)) dut (
        .clkin(clk), .rst_n(rst_n), .syn_md_in(syn), .en(en),
        .period(period), .high_w(high_w), .meas_valid(meas_valid),
        .sync_lock(sync_lock), .sync_lost(sync_lost));

    always #5 clk = ~clk;

    typedef struct {int period; int high; bit lock_before; bit lock_after;} exp_t;
    exp_t sb[$];
    int   n_checks = 0, n_fail = 0;
    int   cyc = 0, last_strobe_cyc = 0;

    // Model state: whole-cycle view of the input, one entry per expected strobe
    bit   have_rise = 0, first = 1;
    int   last_h = 0, last_l = 0, last_p = 0, mcount = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic model_restart();
        have_rise = 0; first = 1; mcount = 0;
    endtask

    task automatic model_rise(input int h, input int l);
        exp_t e;
        int   p, d;
        if (have_rise) begin
            p = last_h + last_l;
            e.period = p; e.high = last_h; e.lock_before = (mcount == LOCK_N);
            d = (p > last_p) ? p - last_p : last_p - p;
            if (first)         mcount = 1;
            else if (d <= TOL) mcount = (mcount < LOCK_N) ? mcount + 1 : LOCK_N;
            else               mcount = 1;
            first = 0; last_p = p;
            e.lock_after = (mcount == LOCK_N);
            sb.push_back(e);
        end
        have_rise = 1; last_h = h; last_l = l;
    endtask

    // hact: 1 = 2-cycle low glitch, 2 = enable drop; lact: 1 = 2-cycle high glitch, 2 = reset pulse
    task automatic drive_cycle(input int h, input int l, input int hact, input int lact);
        int a;
        model_rise(h, l);
        syn = 1'b1;
        if (hact == 0) tick(h);
        else begin
            a = $urandom_range(h - 30, 20);
            tick(a);
            if (hact == 1) begin
                syn = 1'b0; tick(2); syn = 1'b1; tick(h - a - 2);
            end else begin
                chk("lock_before_en_drop", sync_lock, mcount == LOCK_N);
                en = 1'b0; tick(1);
                chk("lock_cleared_by_en", sync_lock, 0);
                chk("period_hold_en", period, last_p);
                tick(4); en = 1'b1; model_restart(); tick(h - a - 5);
            end
        end
        syn = 1'b0;
        if (lact == 0) tick(l);
        else begin
            a = $urandom_range(l - 30, 20);
            tick(a);
            if (lact == 1) begin
                syn = 1'b1; tick(2); syn = 1'b0; tick(l - a - 2);
            end else begin
                rst_n = 1'b0; #1;
                chk("rst_period", period, 0);
                chk("rst_high_w", high_w, 0);
                chk("rst_meas_valid", meas_valid, 0);
                chk("rst_sync_lock", sync_lock, 0);
                chk("rst_sync_lost", sync_lost, 0);
                model_restart();
                tick(1); rst_n = 1'b1; tick(l - a - 1);
            end
        end
    endtask

    // Monitor: every strobe pops one expectation; lock is checked at and after the strobe
    bit pend_after = 0, exp_after = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) pend_after = 0;
        else begin
            if (pend_after) begin
                chk("lock_after_strobe", sync_lock, exp_after);
                pend_after = 0;
            end
            if (meas_valid) begin
                if (sb.size() == 0) chk("unexpected_strobe", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("period", period, e.period);
                    chk("high_w", high_w, e.high);
                    chk("lock_at_strobe", sync_lock, e.lock_before);
                    chk("lost_at_strobe", sync_lost, 0);
                    pend_after = 1; exp_after = e.lock_after;
                    last_strobe_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        tick(3);
        chk("reset_period", period, 0);
        chk("reset_high_w", high_w, 0);
        chk("reset_meas_valid", meas_valid, 0);
        chk("reset_sync_lock", sync_lock, 0);
        chk("reset_sync_lost", sync_lost, 0);
        rst_n = 1'b1; en = 1'b1; tick(5);

        for (int i = 0; i < 7; i++) drive_cycle(300, 700, 0, 0);       // steady train
        for (int i = 0; i < 5; i++) drive_cycle(300, 700, 1, 1);       // rejected glitches
        drive_cycle(150, 4, 0, 0);   drive_cycle(146, 700, 0, 0);      // accepted 4-cycle low
        drive_cycle(300, 300, 0, 0); drive_cycle(4, 396, 0, 0);        // accepted 4-cycle high
        for (int i = 0; i < 10; i++) drive_cycle(300, (i % 2) ? 703 : 700, 0, 0);
        for (int i = 0; i < 6; i++)  drive_cycle(300, 710, 0, 0);      // jump and relock

        // Timeout: input stuck high after a rise
        chk("lost_before_timeout", sync_lost, 0);
        model_rise(TIMEOUT + 1000, 500);
        syn = 1'b1; seen = 0;
        for (int i = 0; i < TIMEOUT + 1000; i++) begin
            tick(1);
            if (!seen && sync_lost) begin
                seen = 1;
                chk("timeout_delay", cyc - last_strobe_cyc, TIMEOUT - 1);
                chk("timeout_lock", sync_lock, 0);
            end
        end
        chk("timeout_seen", seen, 1);
        model_restart();
        syn = 1'b0; tick(500);
        chk("lost_held", sync_lost, 1);
        for (int i = 0; i < 6; i++) drive_cycle(300, 700, 0, 0);

        drive_cycle(300, 700, 2, 0);                                    // enable drop
        for (int i = 0; i < 5; i++) drive_cycle(300, 700, 0, 0);
        drive_cycle(300, 700, 0, 2);                                    // reset pulse
        for (int i = 0; i < 5; i++) drive_cycle(300, 700, 0, 0);

        for (int i = 0; i < 8; i++)
            drive_cycle($urandom_range(400, 60), $urandom_range(600, 60),
                        $urandom_range(1, 0), $urandom_range(1, 0));

        model_rise(20, 0);
        syn = 1'b1; tick(20);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/syn_md_decoder.md
# syn_md_decoder

Receive-side decoder for the SYN_MD sync/modulation pulse train generated on the 2D NMR EC FPGA. It synchronises the asynchronous syn_md input into the clkin domain and rejects glitches. It measures the period and high width of each cycle in clkin ticks, and reports lock and loss-of-sync status to the downstream acquisition timing logic. It is the loop-back/monitor counterpart of syn_md_module.

## Interface
Parameters:
- CNT_W, 16: width of the period and high-width counters and outputs.
- FILT, 3: glitch-filter length in cycles, range 1..15.
- TIMEOUT, 50000: cycles without a filtered rising edge before loss of sync; must be < 2^CNT_W.
- TOL, 4: maximum period difference in cycles between consecutive measurements for them to count as consistent.
- LOCK_N, 4: number of consecutive consistent measurements required for lock.

Ports:
- clkin, in, 1: system clock, 100 MHz.
- rst_n, in, 1: asynchronous active-low reset.
- syn_md_in, in, 1: asynchronous SYN_MD pulse train.
- en, in, 1: decoder enable. When low, the FSM is held in IDLE.
- period, out, CNT_W: last measured period, rising edge to rising edge.
- high_w, out, CNT_W: last measured high time, rising edge to falling edge.
- meas_valid, out, 1: one-cycle strobe when period and high_w update.
- sync_lock, out, 1: level; tracking is stable.
- sync_lost, out, 1: level; timeout or saturation occurred.

## Operation
- Input path: 2-FF synchroniser (s1, s2) feeds a filter.
  - filt changes to the value of s2 only after s2 has differed from filt for FILT consecutive cycles.
  - Any shorter excursion restarts the filter count and is ignored.
- Edge detect: rise = filt & ~filt_d; fall = ~filt & filt_d.
- cnt: CNT_W-bit counter.
  - Loads 1 on rise, otherwise increments.
  - Saturates at 2^CNT_W-1.
- FSM states:
  - IDLE: counter cleared. Go to FIRST when en = 1.
  - FIRST: waiting for the first rise. On rise go to HIGH. Period is not measured yet.
  - HIGH: on fall, latch hw_tmp = cnt and go to LOW.
  - LOW: on rise, period <= cnt, high_w <= hw_tmp, meas_valid = 1; go to HIGH.
  - A rise while in HIGH (no fall seen) is impossible after filtering. Treat it as a restart: go to HIGH with no measurement.
  - From HIGH or LOW: if cnt reaches TIMEOUT, set sync_lost = 1, clear sync_lock, and go to FIRST.
  - From any state: en = 0 returns to IDLE next cycle. Outputs period/high_w hold, sync_lock clears, sync_lost holds.
- Lock counter (0..LOCK_N):
  - On each meas_valid, if |period_new - period_old| <= TOL, increment (saturating).
  - Otherwise reset it to 1.
  - The first measurement after FIRST sets it to 1.
  - sync_lock = 1 when the counter equals LOCK_N.
- sync_lost clears on the next meas_valid.
- Arithmetic: the difference is unsigned and computed in CNT_W+1 bits to avoid wrap.

## Timing
- Reset values: period = 0, high_w = 0, meas_valid = 0, sync_lock = 0, sync_lost = 0, FSM = IDLE, filt = 0, counters = 0.
- Input-to-filt latency is 2 + FILT cycles. It is identical for both edges, so measured widths are exact in cycles (±1 for asynchronous sampling).
- meas_valid is asserted in the cycle after the filtered rise registers. period and high_w are valid in the same cycle and held until the next strobe.
- sync_lock asserts one cycle after the LOCK_N-th consistent meas_valid.
- sync_lost asserts in the cycle cnt == TIMEOUT.
- Reset is asynchronous and may occur mid-frame. The next frame after release starts in IDLE and the first full period is discarded.

## Test plan
- Steady train, en = 1, period 1000 cycles, high 300 cycles:
  - No strobe on the first rise.
  - From the second rise, meas_valid each rise with period = 1000, high_w = 300.
  - sync_lock = 1 after the 4th strobe.
- Glitch rejection, FILT = 3:
  - Inject 2-cycle low glitches inside the high phase and 2-cycle high glitches inside the low phase: measurements stay 1000/300.
  - A 4-cycle glitch is accepted and produces an edge.
- Jitter: alternate periods 1000/1003 keep lock. A jump to 1010 drops sync_lock for the next 3 strobes, after which it relocks.
- Timeout: stop the input high for 60000 cycles.
  - sync_lost = 1 exactly 50000 cycles after the last rise; sync_lock = 0.
  - On restart, the first strobe arrives at the second rise and clears sync_lost.
- Enable/reset mid-operation:
  - Drop en during the high phase: FSM goes to IDLE, sync_lock = 0, period holds.
  - Pulse rst_n low for 1 cycle mid-frame: all outputs read 0 immediately, and the first strobe arrives at the second rise afterwards.
